// File: rtl/lcd_timing_gen_if.sv
// Video timing bus: run request in, sync/active-video/position outputs back.
interface lcd_timing_gen_if;
  logic        en;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  en,
    output hs_out, vs_out, de_out, x_out, y_out, line_start, frame_start
  );
  modport slave (
    output en,
    input  hs_out, vs_out, de_out, x_out, y_out, line_start, frame_start
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: h/v counters with sync-bp-active-fp segments,
// all outputs registered one clock behind the counter state they decode.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  lcd_timing_gen_if.master bus
);
  localparam logic [15:0] H_TOTAL = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [15:0] V_TOTAL = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [15:0] H_SE    = 16'(H_SYNC);
  localparam logic [15:0] V_SE    = 16'(V_SYNC);
  localparam logic [15:0] H_AS    = 16'(H_SYNC + H_BP);
  localparam logic [15:0] V_AS    = 16'(V_SYNC + V_BP);
  localparam logic [15:0] H_AE    = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_AE    = 16'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [15:0] h_cnt, v_cnt;
  logic        h_last, v_last, h_sync, v_sync, h_act, v_act;
  logic        hs_q, vs_q, de_q, ls_q, fs_q;
  logic [15:0] x_q, y_q;

  always_comb begin
    h_last = (h_cnt == H_TOTAL - 16'd1);
    v_last = (v_cnt == V_TOTAL - 16'd1);
    h_sync = (h_cnt < H_SE);
    v_sync = (v_cnt < V_SE);
    h_act  = (h_cnt >= H_AS) && (h_cnt < H_AE);
    v_act  = (v_cnt >= V_AS) && (v_cnt < V_AE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      // Idle defaults; RUN overrides with the decode of the current counters.
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      case (state)
        IDLE: if (bus.en) state <= RUN;
        RUN: begin
          h_cnt <= h_last ? '0 : h_cnt + 16'd1;
          if (h_last) v_cnt <= v_last ? '0 : v_cnt + 16'd1;
          hs_q <= h_sync ? HS_POL : ~HS_POL;
          vs_q <= v_sync ? VS_POL : ~VS_POL;
          de_q <= h_act && v_act;
          x_q  <= (h_act && v_act) ? h_cnt - H_AS : '0;
          y_q  <= (h_act && v_act) ? v_cnt - V_AS : '0;
          ls_q <= v_act && (h_cnt == H_AS);
          fs_q <= (h_cnt == '0) && (v_cnt == '0);
          // en only matters at the very last counter cycle of a frame.
          if (h_last && v_last && !bus.en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hs_out      = hs_q;
  assign bus.vs_out      = vs_q;
  assign bus.de_out      = de_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
endmodule
